// File: rtl/rvv_axi_mem_responder.sv
// AXI4 slave memory with INCR write/read bursts and a programmable read latency.
// Optional define RVV_AXI_MEM_ADDR_CHECK_EN: out-of-range beats are dropped and answered with SLVERR.
module rvv_axi_mem_responder #(
  parameter int DATA_W      = 64,
  parameter int ADDR_W      = 32,
  parameter int ID_W        = 6,
  parameter int DEPTH_WORDS = 4096,
  parameter int RD_LAT      = 2
) (
  input  logic                io_aclk,
  input  logic                io_aresetn,
  input  logic                aw_valid,
  output logic                aw_ready,
  input  logic [ADDR_W-1:0]   aw_addr,
  input  logic [ID_W-1:0]     aw_id,
  input  logic [7:0]          aw_len,
  input  logic                w_valid,
  output logic                w_ready,
  input  logic [DATA_W-1:0]   w_data,
  input  logic [DATA_W/8-1:0] w_strb,
  input  logic                w_last,
  output logic                b_valid,
  input  logic                b_ready,
  output logic [ID_W-1:0]     b_id,
  output logic [1:0]          b_resp,
  input  logic                ar_valid,
  output logic                ar_ready,
  input  logic [ADDR_W-1:0]   ar_addr,
  input  logic [ID_W-1:0]     ar_id,
  input  logic [7:0]          ar_len,
  output logic                r_valid,
  input  logic                r_ready,
  output logic [DATA_W-1:0]   r_data,
  output logic [ID_W-1:0]     r_id,
  output logic [1:0]          r_resp,
  output logic                r_last
);

  localparam int STRB_W  = DATA_W / 8;
  localparam int BYTE_SH = $clog2(STRB_W);
  localparam int IDX_W   = ADDR_W - BYTE_SH;
  localparam int MEM_AW  = $clog2(DEPTH_WORDS);
  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;

`ifdef RVV_AXI_MEM_ADDR_CHECK_EN
  localparam bit ADDR_CHECK = 1'b1;
`else
  localparam bit ADDR_CHECK = 1'b0;
`endif

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} r_state_t;

  w_state_t          w_state_reg;
  logic [IDX_W-1:0]  w_idx_reg;
  logic [7:0]        w_cnt_reg;
  logic              w_err_reg;
  logic              aw_ready_reg;
  logic              w_ready_reg;
  logic              b_valid_reg;
  logic [ID_W-1:0]   b_id_reg;
  logic [1:0]        b_resp_reg;

  r_state_t          r_state_reg;
  logic [IDX_W-1:0]  r_idx_reg;
  logic [7:0]        r_left_reg;
  logic [3:0]        lat_cnt_reg;
  logic              ar_ready_reg;
  logic              r_valid_reg;
  logic              r_last_reg;
  logic [ID_W-1:0]   r_id_reg;
  logic [1:0]        r_resp_reg;

  logic              w_fire;
  logic              w_oor;
  logic              w_beat_last;
  logic              mem_we;
  logic              rd_load;
  logic [IDX_W-1:0]  rd_idx;
  logic              rd_oor;
  logic              unused_addr_bits;

  // Sub-word address bits carry no meaning for full-width INCR bursts.
  assign unused_addr_bits = ^{aw_addr[BYTE_SH-1:0], ar_addr[BYTE_SH-1:0]};

  assign w_fire      = (w_state_reg == W_DATA) && w_valid;
  assign w_oor       = ADDR_CHECK && (w_idx_reg >= IDX_W'(DEPTH_WORDS));
  assign w_beat_last = (w_cnt_reg == 8'd0);
  assign mem_we      = w_fire && !w_oor;

  // The output data register is reloaded on entry to BURST and on every accepted non-last beat.
  assign rd_load = ((r_state_reg == R_WAIT) && (lat_cnt_reg == 4'd0)) ||
                   ((r_state_reg == R_BURST) && r_ready && !r_last_reg);
  assign rd_idx  = (r_state_reg == R_BURST) ? r_idx_reg + IDX_W'(1) : r_idx_reg;
  assign rd_oor  = ADDR_CHECK && (rd_idx >= IDX_W'(DEPTH_WORDS));

  always_ff @(posedge io_aclk or negedge io_aresetn) begin
    if (!io_aresetn) begin
      w_state_reg  <= W_IDLE;
      w_idx_reg    <= '0;
      w_cnt_reg    <= 8'd0;
      w_err_reg    <= 1'b0;
      aw_ready_reg <= 1'b1;
      w_ready_reg  <= 1'b0;
      b_valid_reg  <= 1'b0;
      b_id_reg     <= '0;
      b_resp_reg   <= RESP_OKAY;
    end else begin
      case (w_state_reg)
        W_IDLE: begin
          if (aw_valid && aw_ready_reg) begin
            w_idx_reg    <= aw_addr[ADDR_W-1:BYTE_SH];
            w_cnt_reg    <= aw_len;
            b_id_reg     <= aw_id;
            w_err_reg    <= 1'b0;
            aw_ready_reg <= 1'b0;
            w_ready_reg  <= 1'b1;
            w_state_reg  <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            w_idx_reg <= w_idx_reg + IDX_W'(1);
            w_cnt_reg <= w_cnt_reg - 8'd1;
            w_err_reg <= w_err_reg | w_oor;
            // Either an early w_last or a missing one on the final counted beat ends the burst.
            if (w_last || w_beat_last) begin
              w_ready_reg <= 1'b0;
              b_valid_reg <= 1'b1;
              b_resp_reg  <= (w_err_reg || w_oor || (w_last != w_beat_last)) ? RESP_SLVERR : RESP_OKAY;
              w_state_reg <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (b_ready) begin
            b_valid_reg  <= 1'b0;
            aw_ready_reg <= 1'b1;
            w_state_reg  <= W_IDLE;
          end
        end
        default: begin
          aw_ready_reg <= 1'b1;
          w_ready_reg  <= 1'b0;
          b_valid_reg  <= 1'b0;
          w_state_reg  <= W_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge io_aclk or negedge io_aresetn) begin
    if (!io_aresetn) begin
      r_state_reg  <= R_IDLE;
      r_idx_reg    <= '0;
      r_left_reg   <= 8'd0;
      lat_cnt_reg  <= 4'd0;
      ar_ready_reg <= 1'b1;
      r_valid_reg  <= 1'b0;
      r_last_reg   <= 1'b0;
      r_id_reg     <= '0;
      r_resp_reg   <= RESP_OKAY;
    end else begin
      case (r_state_reg)
        R_IDLE: begin
          if (ar_valid && ar_ready_reg) begin
            r_idx_reg    <= ar_addr[ADDR_W-1:BYTE_SH];
            r_left_reg   <= ar_len;
            r_id_reg     <= ar_id;
            lat_cnt_reg  <= 4'(RD_LAT - 1);
            ar_ready_reg <= 1'b0;
            r_state_reg  <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (lat_cnt_reg == 4'd0) begin
            r_valid_reg <= 1'b1;
            r_last_reg  <= (r_left_reg == 8'd0);
            r_resp_reg  <= rd_oor ? RESP_SLVERR : RESP_OKAY;
            r_state_reg <= R_BURST;
          end else begin
            lat_cnt_reg <= lat_cnt_reg - 4'd1;
          end
        end
        R_BURST: begin
          if (r_ready) begin
            if (r_last_reg) begin
              r_valid_reg  <= 1'b0;
              r_last_reg   <= 1'b0;
              ar_ready_reg <= 1'b1;
              r_state_reg  <= R_IDLE;
            end else begin
              r_idx_reg  <= rd_idx;
              r_left_reg <= r_left_reg - 8'd1;
              r_last_reg <= (r_left_reg == 8'd1);
              r_resp_reg <= rd_oor ? RESP_SLVERR : RESP_OKAY;
            end
          end
        end
        default: begin
          ar_ready_reg <= 1'b1;
          r_valid_reg  <= 1'b0;
          r_last_reg   <= 1'b0;
          r_state_reg  <= R_IDLE;
        end
      endcase
    end
  end

  // One byte-wide RAM per lane keeps strobed writes a plain single-port write.
  genvar gi;
  generate
    for (gi = 0; gi < STRB_W; gi++) begin : g_lane
      logic [7:0] mem_lane [DEPTH_WORDS];
      logic [7:0] r_lane_reg;

      always_ff @(posedge io_aclk) begin
        if (mem_we && w_strb[gi]) begin
          mem_lane[w_idx_reg[MEM_AW-1:0]] <= w_data[gi*8 +: 8];
        end
      end

      always_ff @(posedge io_aclk or negedge io_aresetn) begin
        if (!io_aresetn) begin
          r_lane_reg <= 8'h00;
        end else if (rd_load) begin
          r_lane_reg <= rd_oor ? 8'h00 : mem_lane[rd_idx[MEM_AW-1:0]];
        end
      end

      assign r_data[gi*8 +: 8] = r_lane_reg;
    end
  endgenerate

  assign aw_ready = aw_ready_reg;
  assign w_ready  = w_ready_reg;
  assign b_valid  = b_valid_reg;
  assign b_id     = b_id_reg;
  assign b_resp   = b_resp_reg;
  assign ar_ready = ar_ready_reg;
  assign r_valid  = r_valid_reg;
  assign r_last   = r_last_reg;
  assign r_id     = r_id_reg;
  assign r_resp   = r_resp_reg;

endmodule
